mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Arbitrates one shared main-memory port between the instruction-cache and data-cache miss paths of the Riscv151 core.
Accepts one line request at a time and sequences the address phase, then the write-data burst or read-response burst, on the memory interface.
Routes each read beat back to the requester that owns the transaction.
Sits between the two cache controllers and the memory/DRAM model.

Parameters:
ADDR_WIDTH, 28, line-address width (byte address >> 4)
DATA_WIDTH, 128, beat width
BEATS, 4, beats per line transfer (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
ic_req_valid  in  1  I-side line read request
ic_req_ready  out  1  I-side request accepted
ic_req_addr  in  ADDR_WIDTH  I-side line address
ic_resp_valid  out  1  I-side read beat valid
ic_resp_data  out  DATA_WIDTH  I-side read beat
dc_req_valid  in  1  D-side request
dc_req_ready  out  1  D-side request accepted
dc_req_rnw  in  1  1=read, 0=write
dc_req_addr  in  ADDR_WIDTH  D-side line address
dc_wdata_valid  in  1  D-side write beat valid
dc_wdata_ready  out  1  D-side write beat taken
dc_wdata  in  DATA_WIDTH  D-side write beat
dc_resp_valid  out  1  D-side read beat valid
dc_resp_data  out  DATA_WIDTH  D-side read beat
mem_req_valid  out  1  memory address phase valid
mem_req_ready  in  1  memory address phase accepted
mem_req_rnw  out  1  1=read, 0=write
mem_req_addr  out  ADDR_WIDTH  line address
mem_wdata_valid  out  1  write beat valid
mem_wdata_ready  in  1  write beat accepted
mem_wdata  out  DATA_WIDTH  write beat
mem_resp_valid  in  1  read beat valid
mem_resp_data  in  DATA_WIDTH  read beat
busy  out  1  state != IDLE

Behaviour:
- Clocking: single clock clk; reset is synchronous, active-high.
- FSM states: IDLE, ADDR, WDATA, RDATA. Beat counter width is max(1, clog2(BEATS)).
- Reset values: state=IDLE, counter=0, owner=IC, last_grant=IC. While reset is high, every valid/ready output is 0.
- IDLE, grant: if only one *_req_valid is high, grant that side. If both are high, grant the side != last_grant (round-robin).
  - Only the granted side sees *_req_ready=1. The other side's ready is 0.
- IDLE, accept: on valid&&ready at the clock edge:
  - latch addr, rnw (IC always 1) and owner;
  - last_grant<=owner; counter<=0; go to ADDR.
  - Request-to-mem_req_valid latency is 1 cycle.
- Requesters hold valid/addr until ready; the grant may change between cycles before acceptance.
- ADDR: mem_req_valid=1 with latched addr/rnw. On mem_req_ready, go to WDATA if rnw=0, else RDATA. Otherwise hold.
- WDATA: combinational pass-through.
  - mem_wdata_valid=dc_wdata_valid; dc_wdata_ready=mem_wdata_ready; mem_wdata=dc_wdata.
  - Counter increments on each handshake. Handshake with counter==BEATS-1 goes to IDLE.
  - No response is returned for writes.
- RDATA: mem_resp_valid is routed combinationally to the owner's *_resp_valid (0-cycle latency). Both *_resp_data buses carry mem_resp_data.
  - The non-owner's resp_valid is 0.
  - Counter increments per beat. The beat with counter==BEATS-1 goes to IDLE.
- Outside RDATA, mem_resp_valid is ignored; no resp_valid is raised.
- Outside WDATA, dc_wdata_ready=0 and mem_wdata_valid=0.
- Back-to-back: returning to IDLE allows a new accept in the very next cycle.
- Reset mid-transaction: abort to IDLE next edge; remaining beats are neither driven nor routed.

Optional Feature:
Macro ARB_DCACHE_PRIO_EN.
- Defined: D-side has strict priority. When both valid, the D-side is always granted; last_grant is ignored.
- Undefined: round-robin as above.

Test Plan:
- IC-only read, addr 0x0000010, BEATS=4: ic_req_ready=1 in IDLE; mem_req_valid the next cycle with rnw=1, addr=0x0000010. Four mem_resp beats 0xA0..0xA3 appear on ic_resp with ic_resp_valid=1; dc_resp_valid stays 0; busy clears after beat 3.
- DC write, addr 0x0000200, mem_wdata_ready toggling 1,0,1,1,1: mem_req_rnw=0; exactly 4 beats pass through in order; dc_wdata_ready mirrors mem_wdata_ready; IDLE after the 4th handshake; no dc_resp_valid.
- Both requesting continuously from reset: grants alternate DC, IC, DC, IC. With ARB_DCACHE_PRIO_EN defined: DC, DC, DC.
- mem_req_ready held low 5 cycles: mem_req_valid and addr stay stable; no ready to either requester.
- Stray mem_resp_valid=1 in IDLE and in ADDR: no *_resp_valid asserted; counter stays 0.
- reset asserted after 2 of 4 read beats: next cycle busy=0, all valids 0. A subsequent IC request completes a full 4-beat read correctly.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares one main-memory line port between the I-cache and D-cache miss paths.
// Optional build macro ARB_DCACHE_PRIO_EN gives the D-side strict priority instead of round-robin.
module mem_arbiter #(
   parameter int ADDR_WIDTH = 28,
   parameter int DATA_WIDTH = 128,
   parameter int BEATS      = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ic_req_valid,
   output logic                  ic_req_ready,
   input  logic [ADDR_WIDTH-1:0] ic_req_addr,
   output logic                  ic_resp_valid,
   output logic [DATA_WIDTH-1:0] ic_resp_data,
   input  logic                  dc_req_valid,
   output logic                  dc_req_ready,
   input  logic                  dc_req_rnw,
   input  logic [ADDR_WIDTH-1:0] dc_req_addr,
   input  logic                  dc_wdata_valid,
   output logic                  dc_wdata_ready,
   input  logic [DATA_WIDTH-1:0] dc_wdata,
   output logic                  dc_resp_valid,
   output logic [DATA_WIDTH-1:0] dc_resp_data,
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic                  mem_req_rnw,
   output logic [ADDR_WIDTH-1:0] mem_req_addr,
   output logic                  mem_wdata_valid,
   input  logic                  mem_wdata_ready,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_resp_valid,
   input  logic [DATA_WIDTH-1:0] mem_resp_data,
   output logic                  busy
);

   // state | meaning
   // IDLE  | arbitrating, waiting for a line request
   // ADDR  | presenting latched address/rnw to memory
   // WDATA | passing D-side write beats through to memory
   // RDATA | routing memory read beats to the owning requester

   localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;

`ifdef ARB_DCACHE_PRIO_EN
   localparam bit DC_PRIO = 1'b1;
`else
   localparam bit DC_PRIO = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, ADDR, WDATA, RDATA} state_t;

   state_t                state, state_nxt;
   logic [CW-1:0]         cnt, cnt_nxt;
   logic                  owner, owner_nxt;           // 1 = D-side
   logic                  last_grant, last_grant_nxt; // 1 = D-side
   logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
   logic                  rnw_q, rnw_nxt;
   logic                  grant_dc, grant_ic, last_beat;
   logic                  wr_hs, rd_hs;

   assign grant_dc  = dc_req_valid && (DC_PRIO || !ic_req_valid || !last_grant);
   assign grant_ic  = ic_req_valid && !grant_dc;
   assign last_beat = (cnt == CW'(BEATS - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         owner      <= 1'b0;
         last_grant <= 1'b0;
         addr_q     <= '0;
         rnw_q      <= 1'b1;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         owner      <= owner_nxt;
         last_grant <= last_grant_nxt;
         addr_q     <= addr_nxt;
         rnw_q      <= rnw_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      owner_nxt      = owner;
      last_grant_nxt = last_grant;
      addr_nxt       = addr_q;
      rnw_nxt        = rnw_q;

      // Handshake-visible outputs are gated by reset so nothing leaks while it is held.
      ic_req_ready    = 1'b0;
      dc_req_ready    = 1'b0;
      mem_req_valid   = 1'b0;
      mem_wdata_valid = 1'b0;
      dc_wdata_ready  = 1'b0;
      ic_resp_valid   = 1'b0;
      dc_resp_valid   = 1'b0;
      wr_hs           = 1'b0;
      rd_hs           = 1'b0;

      mem_req_rnw  = rnw_q;
      mem_req_addr = addr_q;
      mem_wdata    = dc_wdata;
      ic_resp_data = mem_resp_data;
      dc_resp_data = mem_resp_data;
      busy         = (state != IDLE);

      case (state)
         IDLE: begin
            ic_req_ready = !reset && grant_ic;
            dc_req_ready = !reset && grant_dc;
            if (grant_ic || grant_dc) begin
               owner_nxt      = grant_dc;
               last_grant_nxt = grant_dc;
               addr_nxt       = grant_dc ? dc_req_addr : ic_req_addr;
               rnw_nxt        = grant_dc ? dc_req_rnw : 1'b1;
               cnt_nxt        = '0;
               state_nxt      = ADDR;
            end
         end
         ADDR: begin
            mem_req_valid = !reset;
            if (mem_req_ready) begin
               state_nxt = rnw_q ? RDATA : WDATA;
            end
         end
         WDATA: begin
            mem_wdata_valid = !reset && dc_wdata_valid;
            dc_wdata_ready  = !reset && mem_wdata_ready;
            wr_hs           = dc_wdata_valid && mem_wdata_ready;
            if (wr_hs) begin
               if (last_beat) begin
                  cnt_nxt   = '0;
                  state_nxt = IDLE;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
         RDATA: begin
            ic_resp_valid = !reset && mem_resp_valid && !owner;
            dc_resp_valid = !reset && mem_resp_valid && owner;
            rd_hs         = mem_resp_valid;
            if (rd_hs) begin
               if (last_beat) begin
                  cnt_nxt   = '0;
                  state_nxt = IDLE;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter against a transaction-level reference model.
module tb_mem_arbiter;

   localparam int AW    = 28;
   localparam int DW    = 128;
   localparam int BEATS = 4;

`ifdef ARB_DCACHE_PRIO_EN
   localparam bit PRIO = 1'b1;
`else
   localparam bit PRIO = 1'b0;
`endif

   logic          clk;
   logic          reset;
   logic          ic_req_valid, ic_req_ready;
   logic [AW-1:0] ic_req_addr;
   logic          ic_resp_valid;
   logic [DW-1:0] ic_resp_data;
   logic          dc_req_valid, dc_req_ready, dc_req_rnw;
   logic [AW-1:0] dc_req_addr;
   logic          dc_wdata_valid, dc_wdata_ready;
   logic [DW-1:0] dc_wdata;
   logic          dc_resp_valid;
   logic [DW-1:0] dc_resp_data;
   logic          mem_req_valid, mem_req_ready, mem_req_rnw;
   logic [AW-1:0] mem_req_addr;
   logic          mem_wdata_valid, mem_wdata_ready;
   logic [DW-1:0] mem_wdata;
   logic          mem_resp_valid;
   logic [DW-1:0] mem_resp_data;
   logic          busy;

   int errors = 0;
   int checks = 0;
   bit m_last_dc;   // model: side granted last (1 = D-side)

   mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BEATS(BEATS)) dut (
      .clk(clk), .reset(reset),
      .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
      .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
      .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_rnw(dc_req_rnw),
      .dc_req_addr(dc_req_addr), .dc_wdata_valid(dc_wdata_valid), .dc_wdata_ready(dc_wdata_ready),
      .dc_wdata(dc_wdata), .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rnw(mem_req_rnw),
      .mem_req_addr(mem_req_addr), .mem_wdata_valid(mem_wdata_valid),
      .mem_wdata_ready(mem_wdata_ready), .mem_wdata(mem_wdata),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      ic_req_valid    = 1'b0;
      ic_req_addr     = '0;
      dc_req_valid    = 1'b0;
      dc_req_rnw      = 1'b1;
      dc_req_addr     = '0;
      dc_wdata_valid  = 1'b0;
      dc_wdata        = '0;
      mem_req_ready   = 1'b0;
      mem_wdata_ready = 1'b0;
      mem_resp_valid  = 1'b0;
      mem_resp_data   = '0;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      clear_inputs();
      step();
      step();
      reset     = 1'b0;
      m_last_dc = 1'b0;
   endtask

   // One full line transaction; the model decides the grant, latched address/rnw and beat routing.
   // wmode: 0 = always ready/valid, 1 = random stalls, 2 = ready pattern 1,0,1,1,1
   task automatic run_txn(input bit ic_v, input bit dc_v, input bit dc_rnw,
                          input logic [AW-1:0] ic_a, input logic [AW-1:0] dc_a,
                          input int stall, input logic [DW-1:0] base, input int wmode,
                          input string tag);
      bit            exp_dc, exp_rnw, rdy, vld, hs;
      logic [AW-1:0] exp_a;
      logic [DW-1:0] got;
      int            cnt, cyc;
      ic_req_valid = ic_v;
      ic_req_addr  = ic_a;
      dc_req_valid = dc_v;
      dc_req_rnw   = dc_rnw;
      dc_req_addr  = dc_a;
      #1;
      exp_dc  = dc_v && (PRIO || !ic_v || !m_last_dc);
      exp_rnw = exp_dc ? dc_rnw : 1'b1;
      exp_a   = exp_dc ? dc_a : ic_a;
      checks++;
      if ({ic_req_ready, dc_req_ready} !== {!exp_dc, exp_dc}) begin
         errors++;
         $display("FAIL %s grant ic/dc_ready got=%b%b exp=%b%b", tag, ic_req_ready, dc_req_ready,
                  !exp_dc, exp_dc);
      end
      step();
      m_last_dc = exp_dc;

      // Address phase: requesters keep asking, stray beats and write handshakes must be ignored.
      for (int k = 0; k <= stall; k++) begin
         ic_req_valid    = 1'b1;
         dc_req_valid    = 1'b1;
         mem_req_ready   = (k == stall);
         mem_resp_valid  = 1'b1;
         dc_wdata_valid  = 1'b1;
         mem_wdata_ready = 1'b1;
         #1;
         checks++;
         if ({mem_req_valid, mem_req_rnw, mem_req_addr} !== {1'b1, exp_rnw, exp_a}) begin
            errors++;
            $display("FAIL %s addr_phase cyc=%0d got v=%b rnw=%b a=%h exp v=1 rnw=%b a=%h", tag, k,
                     mem_req_valid, mem_req_rnw, mem_req_addr, exp_rnw, exp_a);
         end
         checks++;
         if ({ic_req_ready, dc_req_ready, ic_resp_valid, dc_resp_valid, mem_wdata_valid,
              dc_wdata_ready, busy} !== 7'b0000001) begin
            errors++;
            $display("FAIL %s addr_phase_quiet cyc=%0d got=%b exp=0000001", tag, k,
                     {ic_req_ready, dc_req_ready, ic_resp_valid, dc_resp_valid, mem_wdata_valid,
                      dc_wdata_ready, busy});
         end
         step();
      end
      clear_inputs();

      cnt = 0;
      cyc = 0;
      while (cnt < BEATS && cyc < 200) begin
         case (wmode)
            0:       begin rdy = 1'b1; vld = 1'b1; end
            1:       begin rdy = 1'($urandom_range(0, 1)); vld = 1'($urandom_range(0, 1)); end
            default: begin rdy = (cyc != 1); vld = 1'b1; end
         endcase
         if (!exp_rnw) begin
            mem_wdata_ready = rdy;
            dc_wdata_valid  = vld;
            dc_wdata        = base + DW'(cnt);
            mem_resp_valid  = 1'($urandom_range(0, 1));
            hs              = vld && rdy;
         end else begin
            mem_resp_valid  = vld;
            mem_resp_data   = base + DW'(cnt);
            dc_wdata_valid  = 1'b1;
            mem_wdata_ready = 1'b1;
            hs              = vld;
         end
         #1;
         checks++;
         if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_in_data beat=%0d got=%b exp=1", tag, cnt, busy);
         end
         if (!exp_rnw) begin
            checks++;
            if ({mem_wdata_valid, dc_wdata_ready, ic_resp_valid, dc_resp_valid} !== {vld, rdy, 2'b00}) begin
               errors++;
               $display("FAIL %s wdata_ctl beat=%0d got=%b exp=%b%b00", tag, cnt,
                        {mem_wdata_valid, dc_wdata_ready, ic_resp_valid, dc_resp_valid}, vld, rdy);
            end
            checks++;
            if (mem_wdata !== base + DW'(cnt)) begin
               errors++;
               $display("FAIL %s wdata beat=%0d got=%h exp=%h", tag, cnt, mem_wdata, base + DW'(cnt));
            end
         end else begin
            checks++;
            if ({ic_resp_valid, dc_resp_valid, mem_wdata_valid, dc_wdata_ready} !==
                {vld && !exp_dc, vld && exp_dc, 2'b00}) begin
               errors++;
               $display("FAIL %s resp_route beat=%0d got=%b exp=%b%b00", tag, cnt,
                        {ic_resp_valid, dc_resp_valid, mem_wdata_valid, dc_wdata_ready},
                        vld && !exp_dc, vld && exp_dc);
            end
            got = exp_dc ? dc_resp_data : ic_resp_data;
            checks++;
            if (got !== base + DW'(cnt)) begin
               errors++;
               $display("FAIL %s resp_data beat=%0d got=%h exp=%h", tag, cnt, got, base + DW'(cnt));
            end
         end
         if (hs) cnt++;
         step();
         cyc++;
      end
      if (cnt < BEATS) begin
         errors++;
         $display("FAIL %s beat_timeout got=%0d beats exp=%0d", tag, cnt, BEATS);
      end
      clear_inputs();
      #1;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL %s busy_after_last got=%b exp=0", tag, busy);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      clear_inputs();
      ic_req_valid    = 1'b1;
      dc_req_valid    = 1'b1;
      mem_req_ready   = 1'b1;
      mem_resp_valid  = 1'b1;
      dc_wdata_valid  = 1'b1;
      mem_wdata_ready = 1'b1;
      step();
      step();
      checks++;
      if ({ic_req_ready, dc_req_ready, ic_resp_valid, dc_resp_valid, dc_wdata_ready,
           mem_req_valid, mem_wdata_valid, busy} !== 8'b0) begin
         errors++;
         $display("FAIL reset_outputs got=%b exp=00000000", {ic_req_ready, dc_req_ready,
                  ic_resp_valid, dc_resp_valid, dc_wdata_ready, mem_req_valid, mem_wdata_valid, busy});
      end
      reset     = 1'b0;
      m_last_dc = 1'b0;
      clear_inputs();
      step();
   endtask

   task automatic test_ic_read();
      run_txn(1'b1, 1'b0, 1'b1, 28'h0000010, 28'h0, 0, 128'hA0, 0, "ic_read");
   endtask

   task automatic test_dc_write();
      run_txn(1'b0, 1'b1, 1'b0, 28'h0, 28'h0000200, 0, 128'h5000, 2, "dc_write");
   endtask

   task automatic test_stray_resp();
      mem_resp_valid = 1'b1;
      mem_resp_data  = 128'hDEAD;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if ({ic_resp_valid, dc_resp_valid, busy} !== 3'b000) begin
            errors++;
            $display("FAIL stray_idle cyc=%0d got=%b exp=000", k, {ic_resp_valid, dc_resp_valid, busy});
         end
         step();
      end
      mem_resp_valid = 1'b0;
      // Full-length read afterwards shows the beat counter was not advanced by stray beats.
      run_txn(1'b1, 1'b0, 1'b1, 28'h0000040, 28'h0, 2, 128'hB0, 0, "stray_then_read");
   endtask

   task automatic test_stall();
      run_txn(1'b0, 1'b1, 1'b1, 28'h0, 28'h0ABCDE0, 5, 128'hC0, 0, "addr_stall");
   endtask

   task automatic test_arbitration();
      apply_reset();
      for (int t = 0; t < 4; t++)
         run_txn(1'b1, 1'b1, 1'b1, 28'h0000100 + AW'(t), 28'h0000800 + AW'(t), 0,
                 128'h1000 * DW'(t + 1), 0, "arb_both");
   endtask

   task automatic test_reset_mid();
      ic_req_valid = 1'b1;
      ic_req_addr  = 28'h0000300;
      step();
      ic_req_valid  = 1'b0;
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      for (int b = 0; b < 2; b++) begin
         mem_resp_valid = 1'b1;
         mem_resp_data  = 128'hE0 + DW'(b);
         #1;
         checks++;
         if ({ic_resp_valid, ic_resp_data} !== {1'b1, 128'hE0 + DW'(b)}) begin
            errors++;
            $display("FAIL reset_mid_pre beat=%0d got v=%b d=%h exp v=1 d=%h", b, ic_resp_valid,
                     ic_resp_data, 128'hE0 + DW'(b));
         end
         step();
      end
      reset = 1'b1;
      #1;
      checks++;
      if ({ic_resp_valid, dc_resp_valid, ic_req_ready, dc_req_ready, mem_req_valid,
           mem_wdata_valid, dc_wdata_ready} !== 7'b0) begin
         errors++;
         $display("FAIL reset_mid_during got=%b exp=0000000", {ic_resp_valid, dc_resp_valid,
                  ic_req_ready, dc_req_ready, mem_req_valid, mem_wdata_valid, dc_wdata_ready});
      end
      step();
      reset     = 1'b0;
      m_last_dc = 1'b0;
      #1;
      checks++;
      if ({busy, ic_resp_valid, dc_resp_valid, mem_req_valid} !== 4'b0) begin
         errors++;
         $display("FAIL reset_mid_after got=%b exp=0000", {busy, ic_resp_valid, dc_resp_valid,
                  mem_req_valid});
      end
      clear_inputs();
      run_txn(1'b1, 1'b0, 1'b1, 28'h0000310, 28'h0, 0, 128'hF0, 0, "read_after_reset");
   endtask

   task automatic test_random();
      bit ic_v, dc_v;
      for (int t = 0; t < 40; t++) begin
         ic_v = 1'($urandom_range(0, 1));
         dc_v = ic_v ? 1'($urandom_range(0, 1)) : 1'b1;
         run_txn(ic_v, dc_v, 1'($urandom_range(0, 1)), AW'($urandom()), AW'($urandom()),
                 $urandom_range(0, 3), {$urandom(), $urandom(), $urandom(), $urandom()}, 1,
                 "random");
      end
   endtask

   initial begin
      clear_inputs();
      reset     = 1'b1;
      m_last_dc = 1'b0;
      test_reset();
      test_ic_read();
      test_dc_write();
      test_stray_resp();
      test_stall();
      test_arbitration();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
